// File: rtl/leg_cond_pipe.sv
// Two-stage valid/ready branch-condition evaluator (EQ/NE/LT/LE/GT/GE/ALWAYS/NEVER, signed or unsigned) with tag pass-through.
// Optional result/taken saturating counters are built when LEG_COND_PIPE_STATS_EN is defined.
module leg_cond_pipe #(
    parameter int WIDTH     = 8,
    parameter int OPC_WIDTH = 8,
    parameter int TAG_WIDTH = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [OPC_WIDTH-1:0] opcode,
    input  logic [WIDTH-1:0]     input_1,
    input  logic [WIDTH-1:0]     input_2,
    input  logic [TAG_WIDTH-1:0] in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_taken,
    output logic                 out_illegal,
    output logic [TAG_WIDTH-1:0] out_tag
`ifdef LEG_COND_PIPE_STATS_EN
    ,
    input  logic                 stats_clr,
    output logic [CNT_WIDTH-1:0] stat_total,
    output logic [CNT_WIDTH-1:0] stat_taken
`endif
);

    logic                 s1_valid;
    logic [3:0]           s1_cond;
    logic                 s1_sgn;
    logic                 s1_en;
    logic [WIDTH-1:0]     s1_a;
    logic [WIDTH-1:0]     s1_b;
    logic [TAG_WIDTH-1:0] s1_tag;

    logic s1_load;
    logic s2_load;

    // Only the low six opcode bits carry meaning.
    logic unused_opc;
    assign unused_opc = ^opcode;

    assign s2_load  = s1_valid && (!out_valid || out_ready);
    assign in_ready = !rst && (!s1_valid || s2_load);
    assign s1_load  = in_valid && in_ready;

    // Flipping the sign bit maps two's-complement order onto unsigned order.
    logic [WIDTH-1:0] a_key;
    logic [WIDTH-1:0] b_key;
    logic             eq;
    logic             lt;
    logic             taken_nxt;
    logic             illegal_nxt;

    assign a_key = {s1_a[WIDTH-1] ^ s1_sgn, s1_a[WIDTH-2:0]};
    assign b_key = {s1_b[WIDTH-1] ^ s1_sgn, s1_b[WIDTH-2:0]};
    assign eq    = (s1_a == s1_b);
    assign lt    = (a_key < b_key);

    always_comb begin
        taken_nxt   = 1'b0;
        illegal_nxt = 1'b0;
        if (s1_en) begin
            case (s1_cond)
                4'd0:    taken_nxt = eq;
                4'd1:    taken_nxt = !eq;
                4'd2:    taken_nxt = lt;
                4'd3:    taken_nxt = lt || eq;
                4'd4:    taken_nxt = !(lt || eq);
                4'd5:    taken_nxt = !lt;
                4'd6:    taken_nxt = 1'b1;
                4'd7:    taken_nxt = 1'b0;
                default: illegal_nxt = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else if (s1_load) begin
            s1_valid <= 1'b1;
            s1_cond  <= opcode[3:0];
            s1_sgn   <= opcode[4];
            s1_en    <= opcode[5];
            s1_a     <= input_1;
            s1_b     <= input_2;
            s1_tag   <= in_tag;
        end else if (s2_load) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_taken   <= 1'b0;
            out_illegal <= 1'b0;
            out_tag     <= '0;
        end else if (s2_load) begin
            out_valid   <= 1'b1;
            out_taken   <= taken_nxt;
            out_illegal <= illegal_nxt;
            out_tag     <= s1_tag;
        end else if (out_ready) begin
            out_valid   <= 1'b0;
        end
    end

`ifdef LEG_COND_PIPE_STATS_EN
    // A clear wins over a coincident handshake, so that result is not counted.
    always_ff @(posedge clk) begin
        if (rst || stats_clr) begin
            stat_total <= '0;
            stat_taken <= '0;
        end else if (out_valid && out_ready) begin
            if (stat_total != '1) stat_total <= stat_total + 1'b1;
            if (out_taken && (stat_taken != '1)) stat_taken <= stat_taken + 1'b1;
        end
    end
`else
    logic [CNT_WIDTH-1:0] unused_cnt;
    assign unused_cnt = '0;
`endif

endmodule

// File: tb/tb_leg_cond_pipe.sv
// Randomised and directed bench for leg_cond_pipe against an arithmetic reference model and scoreboard.
module tb_leg_cond_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] opcode;
    logic [7:0] input_1;
    logic [7:0] input_2;
    logic [3:0] in_tag;
    logic       out_valid;
    logic       out_ready;
    logic       out_taken;
    logic       out_illegal;
    logic [3:0] out_tag;
`ifdef LEG_COND_PIPE_STATS_EN
    logic       stats_clr;
    logic [3:0] stat_total;
    logic [3:0] stat_taken;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    leg_cond_pipe #(.WIDTH(8), .OPC_WIDTH(8), .TAG_WIDTH(4), .CNT_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .input_1(input_1), .input_2(input_2), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_taken(out_taken),
        .out_illegal(out_illegal), .out_tag(out_tag)
`ifdef LEG_COND_PIPE_STATS_EN
        , .stats_clr(stats_clr), .stat_total(stat_total), .stat_taken(stat_taken)
`endif
    );

    // Reference: interpret operands as integers, compare with plain arithmetic.
    function automatic logic [1:0] model(input logic [7:0] opc, input logic [7:0] a, input logic [7:0] b);
        int x, y;
        x = int'(a);
        y = int'(b);
        if (opc[4] && a[7]) x = x - 256;
        if (opc[4] && b[7]) y = y - 256;
        if (!opc[5]) return 2'b00;
        case (int'(opc[3:0]))
            0: return {x == y, 1'b0};
            1: return {x != y, 1'b0};
            2: return {x <  y, 1'b0};
            3: return {x <= y, 1'b0};
            4: return {x >  y, 1'b0};
            5: return {x >= y, 1'b0};
            6: return 2'b10;
            7: return 2'b00;
            default: return 2'b01;
        endcase
    endfunction

    // Sends one request with out_ready high; reports result and accept-to-valid latency (-1 on timeout).
    task automatic run_one(input logic [7:0] opc, input logic [7:0] a, input logic [7:0] b,
                           input logic [3:0] tg, output logic t, output logic il,
                           output logic [3:0] ot, output int lat);
        lat = -1; t = 1'b0; il = 1'b0; ot = '0;
        out_ready = 1'b1; in_valid = 1'b1; opcode = opc; input_1 = a; input_2 = b; in_tag = tg;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = i; t = out_taken; il = out_illegal; ot = out_tag;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        opcode = 8'h26; input_1 = 8'h00; input_2 = 8'h00; in_tag = 4'hF;
`ifdef LEG_COND_PIPE_STATS_EN
        stats_clr = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        n_tests++;
        if ({out_valid, out_taken, out_illegal, out_tag} !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got=%b%b%b%h exp=0000", out_valid, out_taken, out_illegal, out_tag);
        end
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [7:0] opcs [8] = '{8'h23, 8'h22, 8'h32, 8'h34, 8'h29, 8'h09, 8'h26, 8'h27};
        logic [7:0] as   [8] = '{8'h05, 8'h80, 8'h80, 8'hFF, 8'h10, 8'h10, 8'h00, 8'h00};
        logic [7:0] bs   [8] = '{8'h05, 8'h7F, 8'h7F, 8'h01, 8'h20, 8'h20, 8'h01, 8'h00};
        logic [1:0] exps [8] = '{2'b10, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
        logic t, il;
        logic [3:0] ot, tg;
        int lat;
        for (int i = 0; i < 8; i++) begin
            tg = (i == 0) ? 4'd3 : 4'(i + 5);
            run_one(opcs[i], as[i], bs[i], tg, t, il, ot, lat);
            n_tests++;
            if (lat != 2) begin n_fail++; $display("FAIL latency op=%h got=%0d exp=2", opcs[i], lat); end
            n_tests++;
            if ({t, il, ot} !== {exps[i], tg}) begin
                n_fail++;
                $display("FAIL directed op=%h a=%h b=%h got t=%b il=%b tag=%h exp t=%b il=%b tag=%h",
                         opcs[i], as[i], bs[i], t, il, ot, exps[i][1], exps[i][0], tg);
            end
        end
    endtask

    task automatic test_backpressure();
        int k = 0, drops_at = -1, got = 0, first = -1;
        logic hs;
        opcode = 8'h26; input_1 = 8'h00; input_2 = 8'h00;
        for (int c = 0; c < 5; c++) begin
            in_valid = (k < 4); in_tag = 4'(k); out_ready = 1'b0;
            @(negedge clk);
            if (!in_ready && drops_at < 0) drops_at = k;
            if (out_valid) begin
                n_tests++;
                if (out_tag !== 4'd0) begin n_fail++; $display("FAIL bp_hold_tag got=%h exp=0", out_tag); end
            end
            hs = in_valid && in_ready;
            @(posedge clk); #1;
            if (hs) k++;
        end
        n_tests++;
        if (drops_at != 2) begin n_fail++; $display("FAIL bp_in_ready_drop got=%0d exp=2", drops_at); end
        out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            in_valid = (k < 4); in_tag = 4'(k);
            @(negedge clk);
            if (out_valid) begin
                if (first < 0) first = c;
                n_tests++;
                if (out_tag !== 4'(got) || c != first + got) begin
                    n_fail++;
                    $display("FAIL bp_release got tag=%h cyc=%0d exp tag=%h cyc=%0d", out_tag, c, got[3:0], first + got);
                end
                got++;
            end
            hs = in_valid && in_ready;
            @(posedge clk); #1;
            if (hs) k++;
        end
        in_valid = 1'b0;
        n_tests++;
        if (got != 4) begin n_fail++; $display("FAIL bp_count got=%0d exp=4", got); end
    endtask

    task automatic test_random();
        logic [5:0] q [$];
        logic [1:0] r;
        logic [5:0] e;
        logic       prev_stall = 1'b0;
        logic [5:0] prev_out = '0;
        logic       acc, drn;
        int         drained = 0;
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = (c >= 360) ? 1'b1 : ($urandom_range(0, 2) != 0);
            opcode    = 8'($urandom);
            input_1   = ($urandom_range(0, 3) == 0) ? input_2 : 8'($urandom);
            input_2   = 8'($urandom);
            in_tag    = 4'($urandom);
            if (c >= 360) in_valid = 1'b0;
            @(negedge clk);
            if (prev_stall) begin
                n_tests++;
                if ({out_valid, out_taken, out_illegal, out_tag} !== {1'b1, prev_out}) begin
                    n_fail++;
                    $display("FAIL rand_stall_hold got=%b%b%b%h exp=1%b", out_valid, out_taken, out_illegal, out_tag, prev_out);
                end
            end
            acc = in_valid && in_ready;
            drn = out_valid && out_ready;
            if (acc) begin
                r = model(opcode, input_1, input_2);
                q.push_back({r, in_tag});
            end
            if (drn) begin
                drained++;
                n_tests++;
                if (q.size() == 0) begin
                    n_fail++; $display("FAIL rand_spurious got tag=%h exp none", out_tag);
                end else begin
                    e = q.pop_front();
                    if ({out_taken, out_illegal, out_tag} !== e) begin
                        n_fail++;
                        $display("FAIL rand_result got=%b%b%h exp=%b", out_taken, out_illegal, out_tag, e);
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = {out_taken, out_illegal, out_tag};
            @(posedge clk); #1;
        end
        n_tests++;
        if (q.size() != 0 || drained < 50) begin
            n_fail++; $display("FAIL rand_drain got left=%0d drained=%0d exp left=0 drained>=50", q.size(), drained);
        end
    endtask

    task automatic test_reset_mid();
        int k = 0;
        out_ready = 1'b0; opcode = 8'h26;
        for (int c = 0; c < 6 && k < 2; c++) begin
            in_valid = 1'b1; in_tag = 4'(k + 8);
            @(negedge clk);
            if (in_ready) k++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL mid_reset got vld=%b rdy=%b exp vld=0 rdy=1", out_valid, in_ready);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_tests++;
            if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_stale got=%b exp=0", out_valid); end
        end
        @(posedge clk); #1;
    endtask

`ifdef LEG_COND_PIPE_STATS_EN
    task automatic test_stats();
        int n = 0;
        stats_clr = 1'b1;
        @(posedge clk); #1;
        stats_clr = 1'b0; out_ready = 1'b1; opcode = 8'h26;
        for (int c = 0; c < 60 && n < 20; c++) begin
            in_valid = 1'b1;
            @(negedge clk);
            if (out_valid) n++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (n != 20 || stat_total !== 4'hF || stat_taken !== 4'hF) begin
            n_fail++; $display("FAIL stats_sat got n=%0d total=%h taken=%h exp n=20 total=f taken=f", n, stat_total, stat_taken);
        end
        @(posedge clk); #1;
        in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_valid) break;
            if (in_ready) in_valid = 1'b0;
        end
        stats_clr = 1'b1;
        @(posedge clk); #1;
        stats_clr = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (stat_total !== 4'h0 || stat_taken !== 4'h0) begin
            n_fail++; $display("FAIL stats_clr got total=%h taken=%h exp 0 0", stat_total, stat_taken);
        end
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_random();
        test_reset_mid();
`ifdef LEG_COND_PIPE_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
